evt_spike_merger: RTL and testbench

- Sits directly downstream of the memory sequencer's per-group spike outputs (DP_GROUP parallel spike streams, one per datapath group).
- Buffers each group's spike events in a small per-group FIFO.
- Merges the groups round-robin into a single registered spike stream for the engine output path.
- Tags every output event with its source group index.

---
 rtl/sne_evt_stream_pkg.sv | 20 ++
 rtl/evt_spike_merger_rr_arb.sv | 47 ++++
 rtl/evt_spike_merger.sv | 139 +++++++++++++
 tb/tb_evt_spike_merger.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sne_evt_stream_pkg.sv
// Shared types and constants for the engine event-stream blocks (spike merger and friends).
package sne_evt_stream_pkg;

    localparam int unsigned MERGER_DP_GROUP         = 16;
    localparam int unsigned MERGER_GID_W            = $clog2(MERGER_DP_GROUP);
    localparam int unsigned SPIKE_MERGER_FIFO_DEPTH = 4;
    localparam int unsigned SPIKE_EVT_W             = 32;

    typedef logic [MERGER_GID_W-1:0] merger_gid_t;

    // One spike event word as produced by the memory sequencer.
    typedef struct packed {
        logic [3:0] operation;
        logic [3:0] unused;
        logic [7:0] cid;
        logic [7:0] yid;
        logic [7:0] xid;
    } spike_t;

endpackage

// File: rtl/evt_spike_merger_rr_arb.sv
// Round-robin arbiter: combinational grant search from a registered pointer,
// pointer advances past the winner only on an actual grant.
module evt_spike_merger_rr_arb #(
    parameter  int unsigned N  = 16,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic          engine_clk_i,
    input  logic          engine_rst_i,
    input  logic          flush_i,
    input  logic [N-1:0]  req,
    input  logic          grant_en,
    output logic [N-1:0]  grant_c,
    output logic [IW-1:0] grant_idx_c
);

    logic [IW-1:0] ptr_q;
    logic          found;
    int unsigned   j;

    // First requester at or above the pointer, wrapping to zero.
    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        found       = 1'b0;
        j           = 0;
        for (int unsigned off = 0; off < N; off++) begin
            j = 32'(ptr_q) + off;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found       = 1'b1;
                grant_c[j]  = 1'b1;
                grant_idx_c = IW'(j);
            end
        end
    end

    always_ff @(posedge engine_clk_i or posedge engine_rst_i) begin
        if (engine_rst_i) begin
            ptr_q <= '0;
        end else if (flush_i) begin
            ptr_q <= '0;
        end else if (grant_en && found) begin
            ptr_q <= (grant_idx_c == IW'(N - 1)) ? '0 : grant_idx_c + IW'(1);
        end
    end

endmodule

// File: rtl/evt_spike_merger.sv
// Buffers DP_GROUP spike streams in per-group FIFOs and merges them round-robin
// into one registered, group-tagged stream. Optional perf counters: SNE_SPIKE_MERGER_PERF_EN.
module evt_spike_merger
    import sne_evt_stream_pkg::*;
#(
    parameter  int unsigned DP_GROUP    = MERGER_DP_GROUP,
    parameter  int unsigned EVT_WIDTH   = SPIKE_EVT_W,
    parameter  int unsigned FIFO_DEPTH  = SPIKE_MERGER_FIFO_DEPTH,
    parameter  int unsigned AFULL_LEVEL = 3,
    localparam int unsigned GID_W       = $clog2(DP_GROUP)
) (
    input  logic                          engine_clk_i,
    input  logic                          engine_rst_i,
    input  logic                          flush_i,
    input  logic [DP_GROUP-1:0]           evt_valid_i,
    output logic [DP_GROUP-1:0]           evt_ready_o,
    input  logic [DP_GROUP*EVT_WIDTH-1:0] evt_data_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [EVT_WIDTH-1:0]          out_data_o,
    output logic [GID_W-1:0]              out_group_o,
    output logic [DP_GROUP-1:0]           group_afull_o,
    output logic                          idle_o
`ifdef SNE_SPIKE_MERGER_PERF_EN
    ,
    output logic [31:0]                   perf_evt_cnt_o,
    output logic [31:0]                   perf_stall_cnt_o
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DP_GROUP-1:0]  fifo_empty;
    logic [DP_GROUP-1:0]  fifo_full;
    logic [DP_GROUP-1:0]  push;
    logic [DP_GROUP-1:0]  pop;
    logic [DP_GROUP-1:0]  grant;
    logic [GID_W-1:0]     grant_idx;
    logic [EVT_WIDTH-1:0] head [DP_GROUP];
    logic                 load;
    logic                 any_req;
    logic                 grant_en;

    assign load     = ~out_valid_o | out_ready_i;
    assign any_req  = |(~fifo_empty);
    assign grant_en = load & ~flush_i;
    assign pop      = grant & {DP_GROUP{grant_en}};
    assign idle_o   = (&fifo_empty) & ~out_valid_o;

    for (genvar g = 0; g < DP_GROUP; g++) begin : g_fifo
        logic [EVT_WIDTH-1:0] mem [FIFO_DEPTH];
        logic [PW-1:0]        wr_ptr;
        logic [PW-1:0]        rd_ptr;
        logic [PW-1:0]        occ_nxt;
        logic                 afull_q;

        assign fifo_full[g]  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
        assign fifo_empty[g] = (wr_ptr == rd_ptr);
        // Ready is pure FIFO state; a flush forces it high because the push is dropped anyway.
        assign evt_ready_o[g] = ~fifo_full[g] | flush_i;
        assign push[g]        = evt_valid_i[g] & ~fifo_full[g] & ~flush_i;
        assign head[g]        = mem[rd_ptr[AW-1:0]];
        assign occ_nxt        = wr_ptr - rd_ptr + PW'(push[g]) - PW'(pop[g]);
        assign group_afull_o[g] = afull_q;

        always_ff @(posedge engine_clk_i) begin
            if (push[g]) mem[wr_ptr[AW-1:0]] <= evt_data_i[g*EVT_WIDTH +: EVT_WIDTH];
        end

        always_ff @(posedge engine_clk_i or posedge engine_rst_i) begin
            if (engine_rst_i) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                afull_q <= 1'b0;
            end else if (flush_i) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                afull_q <= 1'b0;
            end else begin
                if (push[g]) wr_ptr <= wr_ptr + PW'(1);
                if (pop[g])  rd_ptr <= rd_ptr + PW'(1);
                afull_q <= (occ_nxt >= PW'(AFULL_LEVEL));
            end
        end
    end

    evt_spike_merger_rr_arb #(
        .N (DP_GROUP)
    ) u_arb (
        .engine_clk_i (engine_clk_i),
        .engine_rst_i (engine_rst_i),
        .flush_i      (flush_i),
        .req          (~fifo_empty),
        .grant_en     (grant_en),
        .grant_c      (grant),
        .grant_idx_c  (grant_idx)
    );

    // Output register: reload whenever empty or being consumed.
    always_ff @(posedge engine_clk_i or posedge engine_rst_i) begin
        if (engine_rst_i) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_group_o <= '0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_group_o <= '0;
        end else if (load) begin
            if (any_req) begin
                out_valid_o <= 1'b1;
                out_data_o  <= head[grant_idx];
                out_group_o <= grant_idx;
            end else begin
                out_valid_o <= 1'b0;
            end
        end
    end

`ifdef SNE_SPIKE_MERGER_PERF_EN
    // Saturating handshake and stall counters.
    always_ff @(posedge engine_clk_i or posedge engine_rst_i) begin
        if (engine_rst_i) begin
            perf_evt_cnt_o   <= '0;
            perf_stall_cnt_o <= '0;
        end else if (flush_i) begin
            perf_evt_cnt_o   <= '0;
            perf_stall_cnt_o <= '0;
        end else begin
            if (out_valid_o && out_ready_i && (perf_evt_cnt_o != 32'hFFFF_FFFF))
                perf_evt_cnt_o <= perf_evt_cnt_o + 32'd1;
            if (out_valid_o && !out_ready_i && (perf_stall_cnt_o != 32'hFFFF_FFFF))
                perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_evt_spike_merger.sv
// Directed self-checking bench for evt_spike_merger; perf checks under SNE_SPIKE_MERGER_PERF_EN.
module tb_evt_spike_merger;

    localparam int unsigned DP_GROUP  = 16;
    localparam int unsigned EVT_WIDTH = 32;

    logic                          engine_clk_i = 1'b0;
    logic                          engine_rst_i;
    logic                          flush_i;
    logic [DP_GROUP-1:0]           evt_valid_i;
    logic [DP_GROUP-1:0]           evt_ready_o;
    logic [DP_GROUP*EVT_WIDTH-1:0] evt_data_i;
    logic                          out_valid_o;
    logic                          out_ready_i;
    logic [EVT_WIDTH-1:0]          out_data_o;
    logic [3:0]                    out_group_o;
    logic [DP_GROUP-1:0]           group_afull_o;
    logic                          idle_o;
`ifdef SNE_SPIKE_MERGER_PERF_EN
    logic [31:0]                   perf_evt_cnt_o;
    logic [31:0]                   perf_stall_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 engine_clk_i = ~engine_clk_i;

    evt_spike_merger dut (
        .engine_clk_i  (engine_clk_i),
        .engine_rst_i  (engine_rst_i),
        .flush_i       (flush_i),
        .evt_valid_i   (evt_valid_i),
        .evt_ready_o   (evt_ready_o),
        .evt_data_i    (evt_data_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_data_o    (out_data_o),
        .out_group_o   (out_group_o),
        .group_afull_o (group_afull_o),
        .idle_o        (idle_o)
`ifdef SNE_SPIKE_MERGER_PERF_EN
        ,
        .perf_evt_cnt_o   (perf_evt_cnt_o),
        .perf_stall_cnt_o (perf_stall_cnt_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge engine_clk_i);
        #1;
    endtask

    task automatic set_evt(input int g, input logic [31:0] d);
        evt_valid_i[g] = 1'b1;
        evt_data_i[g*EVT_WIDTH +: EVT_WIDTH] = d;
    endtask

    initial begin
        engine_rst_i = 1'b1;
        flush_i      = 1'b0;
        evt_valid_i  = '0;
        evt_data_i   = '0;
        out_ready_i  = 1'b0;
        repeat (2) @(posedge engine_clk_i);
        #1;
        chk("rst_valid", 32'(out_valid_o), 32'd0);
        chk("rst_data", out_data_o, 32'd0);
        chk("rst_group", 32'(out_group_o), 32'd0);
        chk("rst_ready", 32'(evt_ready_o), 32'hFFFF);
        chk("rst_afull", 32'(group_afull_o), 32'd0);
        chk("rst_idle", 32'(idle_o), 32'd1);
        engine_rst_i = 1'b0;

        // Single event, two-edge latency.
        out_ready_i = 1'b1;
        set_evt(5, 32'h0000_1234);
        step();
        evt_valid_i = '0;
        chk("single_valid_e0", 32'(out_valid_o), 32'd0);
        chk("single_idle_e0", 32'(idle_o), 32'd0);
        step();
        chk("single_valid_e1", 32'(out_valid_o), 32'd1);
        chk("single_data", out_data_o, 32'h0000_1234);
        chk("single_group", 32'(out_group_o), 32'd5);
        step();
        chk("single_valid_e2", 32'(out_valid_o), 32'd0);
        chk("single_idle_e2", 32'(idle_o), 32'd1);

        // Flush resets the RR pointer to 0.
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;

        // All groups at once: group order 0..15, no bubbles.
        for (int g = 0; g < 16; g++) set_evt(g, 32'hA000_0000 | 32'(g));
        step();
        evt_valid_i = '0;
        for (int k = 0; k < 16; k++) begin
            step();
            chk($sformatf("all16_valid%0d", k), 32'(out_valid_o), 32'd1);
            chk($sformatf("all16_group%0d", k), 32'(out_group_o), 32'(k));
            chk($sformatf("all16_data%0d", k), out_data_o, 32'hA000_0000 | 32'(k));
        end
        step();
        chk("all16_drained", 32'(out_valid_o), 32'd0);

        // Occupy the output register, then fill group 2 to full.
        out_ready_i = 1'b0;
        set_evt(7, 32'h0000_7777);
        step();
        evt_valid_i = '0;
        step();
        chk("fill_hold_valid", 32'(out_valid_o), 32'd1);
        chk("fill_hold_group", 32'(out_group_o), 32'd7);
        for (int k = 0; k < 4; k++) begin
            set_evt(2, 32'h2000_0000 + 32'(k));
            step();
            chk($sformatf("fill_afull%0d", k), 32'(group_afull_o[2]), 32'(k >= 2));
            chk($sformatf("fill_ready%0d", k), 32'(evt_ready_o[2]), 32'(k < 3));
            chk($sformatf("fill_stable%0d", k), out_data_o, 32'h0000_7777);
        end
        evt_valid_i = '0;
        out_ready_i = 1'b1;
        chk("full_pop_ready_same_cycle", 32'(evt_ready_o[2]), 32'd0);
        step();
        chk("full_pop_ready_after", 32'(evt_ready_o[2]), 32'd1);
        chk("drain2_group", 32'(out_group_o), 32'd2);
        for (int k = 0; k < 4; k++) begin
            if (k != 0) step();
            chk($sformatf("drain2_data%0d", k), out_data_o, 32'h2000_0000 + 32'(k));
        end
        step();
        chk("drain2_empty", 32'(out_valid_o), 32'd0);

        // Pointer now 3: groups 1 and 3 pending -> 3, 1, 3.
        set_evt(1, 32'h0001_0001);
        set_evt(3, 32'h0003_0001);
        step();
        evt_valid_i[1] = 1'b0;
        set_evt(3, 32'h0003_0002);
        step();
        evt_valid_i = '0;
        chk("rr_g0", 32'(out_group_o), 32'd3);
        chk("rr_d0", out_data_o, 32'h0003_0001);
        step();
        chk("rr_g1", 32'(out_group_o), 32'd1);
        chk("rr_d1", out_data_o, 32'h0001_0001);
        step();
        chk("rr_g2", 32'(out_group_o), 32'd3);
        chk("rr_d2", out_data_o, 32'h0003_0002);
        step();
        chk("rr_done", 32'(out_valid_o), 32'd0);

        // Flush with data buffered and the output register loaded.
        out_ready_i = 1'b0;
        set_evt(4, 32'h0004_0004);
        set_evt(8, 32'h0008_0008);
        set_evt(9, 32'h0009_0009);
        step();
        evt_valid_i = '0;
        step();
        chk("preflush_valid", 32'(out_valid_o), 32'd1);
        chk("preflush_group", 32'(out_group_o), 32'd4);
        flush_i = 1'b1;
        set_evt(10, 32'h0000_DEAD);
        chk("flush_ready", 32'(evt_ready_o), 32'hFFFF);
        step();
        flush_i     = 1'b0;
        evt_valid_i = '0;
        chk("flush_valid", 32'(out_valid_o), 32'd0);
        chk("flush_idle", 32'(idle_o), 32'd1);
        out_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("flush_no_stale%0d", k), 32'(out_valid_o), 32'd0);
        end

        // Asynchronous reset between edges discards the in-flight event.
        set_evt(0, 32'h0000_0BAD);
        step();
        evt_valid_i = '0;
        step();
        chk("prerst_valid", 32'(out_valid_o), 32'd1);
        #1 engine_rst_i = 1'b1;
        #1;
        chk("midrst_valid", 32'(out_valid_o), 32'd0);
        chk("midrst_idle", 32'(idle_o), 32'd1);
        step();
        engine_rst_i = 1'b0;

`ifdef SNE_SPIKE_MERGER_PERF_EN
        chk("perf_rst_evt", perf_evt_cnt_o, 32'd0);
        chk("perf_rst_stall", perf_stall_cnt_o, 32'd0);
        out_ready_i = 1'b1;
        for (int g = 0; g < 10; g++) set_evt(g, 32'hC000_0000 | 32'(g));
        step();
        evt_valid_i = '0;
        repeat (5) step();
        out_ready_i = 1'b0;
        repeat (4) step();
        out_ready_i = 1'b1;
        repeat (10) step();
        chk("perf_evt", perf_evt_cnt_o, 32'd10);
        chk("perf_stall", perf_stall_cnt_o, 32'd4);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("perf_flush_evt", perf_evt_cnt_o, 32'd0);
        chk("perf_flush_stall", perf_stall_cnt_o, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
